// File: rtl/jarch_pkg.sv
// Shared constants and fetch FSM state type for the jarch core.
package jarch_pkg;

  localparam int unsigned ADDR_W  = 16;
  localparam int unsigned INSTR_W = 32;
  localparam int unsigned WAIT_W  = 8;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    HOLD = 3'd2,
    STEP = 3'd3,
    ERR  = 3'd4
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch_unit.sv
// Fetch sequencer: reads PC, fetches one instruction over req/ack, hands it to the
// decoder over valid/ready, then pulses pc_step once per consumed instruction.
module instr_fetch_unit #(
  parameter int unsigned ADDR_W   = jarch_pkg::ADDR_W,
  parameter int unsigned INSTR_W  = jarch_pkg::INSTR_W,
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               enable,
  input  logic [ADDR_W-1:0]  pc,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic               pc_step,
  output logic               fetch_timeout
);
  import jarch_pkg::*;

  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);

  fetch_state_t       state_q, state_d;
  logic [WAIT_W-1:0]  wait_cnt, wait_cnt_d;
  logic [WAIT_W-1:0]  wait_inc;
  logic               req_d, valid_d, step_d, timeout_d;
  logic [ADDR_W-1:0]  addr_d, instr_pc_d;
  logic [INSTR_W-1:0] instr_d;

  assign wait_inc = wait_cnt + WAIT_W'(1);

  // State and registered-output flops
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      wait_cnt      <= '0;
      imem_req      <= 1'b0;
      imem_addr     <= '0;
      instr         <= '0;
      instr_pc      <= '0;
      instr_valid   <= 1'b0;
      pc_step       <= 1'b0;
      fetch_timeout <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt      <= wait_cnt_d;
      imem_req      <= req_d;
      imem_addr     <= addr_d;
      instr         <= instr_d;
      instr_pc      <= instr_pc_d;
      instr_valid   <= valid_d;
      pc_step       <= step_d;
      fetch_timeout <= timeout_d;
    end
  end

  // Next-state and next-output logic; ack takes priority over the wait limit
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt;
    req_d      = imem_req;
    addr_d     = imem_addr;
    instr_d    = instr;
    instr_pc_d = instr_pc;
    valid_d    = instr_valid;
    step_d     = 1'b0;
    timeout_d  = fetch_timeout;

    unique case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = REQ;
          addr_d  = pc;
          req_d   = 1'b1;
        end
      end
      REQ: begin
        if (imem_ack) begin
          instr_d    = imem_data;
          instr_pc_d = imem_addr;
          valid_d    = 1'b1;
          req_d      = 1'b0;
          wait_cnt_d = '0;
          state_d    = HOLD;
        end else if (wait_inc == WAIT_LIMIT) begin
          wait_cnt_d = wait_inc;
          req_d      = 1'b0;
          timeout_d  = 1'b1;
          state_d    = ERR;
        end else begin
          wait_cnt_d = wait_inc;
        end
      end
      HOLD: begin
        if (instr_valid && instr_ready) begin
          valid_d = 1'b0;
          step_d  = 1'b1;
          state_d = STEP;
        end
      end
      STEP: begin
        // PC has already moved on the negedge inside this cycle
        if (enable) begin
          state_d = REQ;
          addr_d  = pc;
          req_d   = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      ERR: begin
        req_d     = 1'b0;
        valid_d   = 1'b0;
        timeout_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
